uart_rx_oversampler: RTL and testbench
======================================

// Module: uart_rx_oversampler
// PURPOSE
//   Parametrised successor to the UART RX single-point data sampler. It synchronises the raw
//   RX line and takes NUM_SAMPLES oversampled readings centred on each bit period, with
//   prescale (oversampling ratio) set at run time. A majority vote gives one bit decision per
//   bit period, with a valid strobe and a noise flag. It sits between the RX edge/bit counter
//   and the RX FSM / deserialiser / parity and stop checkers.
// PARAMETERS
//   PRESCALE_W   6   width of prescale and edge_cnt; max ratio 2**PRESCALE_W-1
//   NUM_SAMPLES  3   samples per bit; odd, 1..7
//   SYNC_STAGES  2   RX input synchroniser depth; >=2
// PORTS
//   clk            in   1            oversampling clock (prescale x baud)
//   rst            in   1            asynchronous reset, active-high
//   rx_in          in   1            raw serial RX line, idle high
//   sample_enable  in   1            RX FSM enables sampling of the current bit period
//   prescale       in   PRESCALE_W   oversampling ratio, even, quasi-static
//   edge_cnt       in   PRESCALE_W   position within bit period, 0..prescale-1, from edge counter
//   sampled_bit    out  1            majority-voted bit value
//   sampled_valid  out  1            1-cycle strobe: sampled_bit is new this cycle
//   noise_flag     out  1            samples of the strobed bit disagreed; qualified by sampled_valid
//   cfg_err        out  1            prescale illegal (odd, or < 2*NUM_SAMPLES)
// BEHAVIOUR
//   - Reset: all sync flops=1, sample shift reg=0, sample count=0, sampled_bit=1,
//     sampled_valid=0, noise_flag=0. cfg_err is combinational from prescale.
//   - rx_sync = rx_in delayed SYNC_STAGES clk. Upstream edge_cnt is aligned to rx_sync.
//   - Sample points: C = prescale>>1, H = (NUM_SAMPLES-1)/2. Sample on each clk where
//     sample_enable=1 and edge_cnt is in C-H..C+H inclusive. Shift rx_sync in and increment
//     the sample count. NUM_SAMPLES=1 degenerates to a single sample at C.
//   - Decision: on the clk where the last point (edge_cnt==C+H) is captured, the count reaches
//     NUM_SAMPLES. On the next clk (latency 1), register:
//     - sampled_bit = 1 iff number of ones > H;
//     - noise_flag = 1 iff the samples are not all equal;
//     - sampled_valid = 1 for exactly one cycle.
//     Then clear the count and shift reg.
//   - Only a full set gives a strobe. If the count != NUM_SAMPLES at C+H, for example because
//     enable rose mid-window, discard the partial set: no strobe, count cleared.
//   - sample_enable=0: count and shift reg clear on the next clk. sampled_valid=0.
//     sampled_bit and noise_flag hold their last values (no forced 0).
//   - cfg_err=1: no samples taken, sampled_valid stays 0, other outputs hold.
//     Clearing prescale resumes at the next full window.
//   - edge_cnt >= prescale (out of range): ignored, no sample.
//   - The prescale change rule is up to the caller. Changing prescale mid-window may lose one bit
//     (partial set discarded); there is no other corruption.
//   - Async rst mid-window: immediate return to reset values. No strobe for the aborted bit.
//   - Back-to-back bits: the strobe for bit n occurs at edge_cnt C+H+1 of bit n, long before
//     bit n+1's window. No overlap is possible when prescale is legal.
// TESTING
//   1. prescale=16, N=3, enable=1, rx steady 0 for a full bit -> samples at edge_cnt 7,8,9.
//      sampled_valid at edge_cnt 10, sampled_bit=0, noise_flag=0.
//   2. prescale=8, rx=1 with a 1-clk glitch to 0 on the sample at edge_cnt 4 ->
//      sampled_bit=1, noise_flag=1, one strobe.
//   3. Enable rises at edge_cnt 8 (prescale=16) -> no strobe this bit.
//      Next full bit strobes normally.
//   4. prescale=5 or prescale=4 with N=3 -> cfg_err=1, no strobes over 3 bit periods.
//      prescale=16 -> strobes resume.
//   5. rst pulse at edge_cnt 8 -> outputs return to reset values immediately, no strobe.
//      After release, first full bit decoded correctly.
//   6. prescale=32, N=5, 0x55 pattern over 10 bits -> 10 strobes at edge_cnt 19,
//      bits alternate correctly, noise_flag=0.

Source files
------------

// File: rtl/uart_rx_oversampler_if.sv
// Bundle between the RX edge counter / FSM side and the oversampling bit sampler.
// The master drives the line, the enable and the position in the bit; the slave returns the voted bit.
interface uart_rx_oversampler_if #(
    parameter int PRESCALE_W = 6
);
    logic                  rx_in;
    logic                  sample_enable;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic                  sampled_bit;
    logic                  sampled_valid;
    logic                  noise_flag;
    logic                  cfg_err;

    modport master (
        output rx_in, sample_enable, prescale, edge_cnt,
        input  sampled_bit, sampled_valid, noise_flag, cfg_err
    );

    modport slave (
        input  rx_in, sample_enable, prescale, edge_cnt,
        output sampled_bit, sampled_valid, noise_flag, cfg_err
    );
endinterface

// File: rtl/uart_rx_oversampler.sv
// UART RX oversampler: synchronises the line, takes NUM_SAMPLES readings centred in each
// bit period and majority-votes them into one bit with a valid strobe and a noise flag.
module uart_rx_oversampler #(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_rx_oversampler_if.slave   bus
);
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
    localparam int HALF  = (NUM_SAMPLES - 1) / 2;
    localparam int PW    = PRESCALE_W + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_sync;

    logic [NUM_SAMPLES-1:0] shift_q, shift_d, shift_in;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       ones;
    logic                   bit_q, bit_d;
    logic                   noise_q, noise_d;
    logic                   valid_q, valid_d;

    logic [PW-1:0]          ps_ext, edge_ext, center, win_lo, win_hi;
    logic                   cfg_err;
    logic                   in_window;
    logic                   take;
    logic                   last_point;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx_in};
        end
    end

    assign rx_sync = sync_q[SYNC_STAGES-1];

    // Widened by one bit so the window bounds never wrap for legal prescale values.
    assign ps_ext     = {1'b0, bus.prescale};
    assign edge_ext   = {1'b0, bus.edge_cnt};
    assign center     = ps_ext >> 1;
    assign win_lo     = center - PW'(HALF);
    assign win_hi     = center + PW'(HALF);
    assign cfg_err    = ps_ext[0] | (ps_ext < PW'(2 * NUM_SAMPLES));
    assign in_window  = (edge_ext >= win_lo) && (edge_ext <= win_hi) && (edge_ext < ps_ext);
    assign take       = bus.sample_enable & ~cfg_err & in_window;
    assign last_point = take & (edge_ext == win_hi);

    assign shift_in = NUM_SAMPLES'({shift_q, rx_sync});

    always_comb begin
        ones = '0;
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            ones = ones + CNT_W'(shift_in[i]);
        end
    end

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        noise_d = noise_q;
        valid_d = 1'b0;

        if (!bus.sample_enable || cfg_err || !in_window) begin
            // A partial set can only live inside the window; anything else discards it.
            shift_d = '0;
            cnt_d   = '0;
        end else if (take) begin
            if (last_point) begin
                if (cnt_q == CNT_W'(NUM_SAMPLES - 1)) begin
                    bit_d   = (ones > CNT_W'(HALF));
                    noise_d = (ones != '0) && (ones != CNT_W'(NUM_SAMPLES));
                    valid_d = 1'b1;
                end
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = shift_in;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            bit_q   <= 1'b1;
            noise_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            noise_q <= noise_d;
            valid_q <= valid_d;
        end
    end

    assign bus.sampled_bit   = bit_q;
    assign bus.sampled_valid = valid_q;
    assign bus.noise_flag    = noise_q;
    assign bus.cfg_err       = cfg_err;
endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler: a 3-sample and a 5-sample instance share one stimulus.
module tb_uart_rx_oversampler;
    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       sample_enable;
    logic [5:0] prescale;
    logic [5:0] edge_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_oversampler_if #(.PRESCALE_W(6)) bus_a ();
    uart_rx_oversampler_if #(.PRESCALE_W(6)) bus_b ();

    assign bus_a.rx_in         = rx_in;
    assign bus_a.sample_enable = sample_enable;
    assign bus_a.prescale      = prescale;
    assign bus_a.edge_cnt      = edge_cnt;
    assign bus_b.rx_in         = rx_in;
    assign bus_b.sample_enable = sample_enable;
    assign bus_b.prescale      = prescale;
    assign bus_b.edge_cnt      = edge_cnt;

    uart_rx_oversampler #(.PRESCALE_W(6), .NUM_SAMPLES(3), .SYNC_STAGES(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    uart_rx_oversampler #(.PRESCALE_W(6), .NUM_SAMPLES(5), .SYNC_STAGES(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One bit period. rx_in leads rx_sync by two clocks, so the value driven at position e
    // is the one the sampler sees at position e+2; glitch names the sampler-side position.
    task automatic run_bit(input string tag, input logic use_b, input int ps, input logic val,
                           input int glitch, input int en_from, input int exp_strobes,
                           input int exp_pos, input logic exp_bit, input logic exp_noise);
        int   strobes = 0;
        int   pos     = -1;
        logic got_bit = 1'bx;
        logic got_noise = 1'bx;
        logic v;
        prescale = ps[5:0];
        for (int e = 0; e < ps; e++) begin
            @(negedge clk);
            v = use_b ? bus_b.sampled_valid : bus_a.sampled_valid;
            if (v) begin
                strobes++;
                pos       = e;
                got_bit   = use_b ? bus_b.sampled_bit : bus_a.sampled_bit;
                got_noise = use_b ? bus_b.noise_flag  : bus_a.noise_flag;
            end
            edge_cnt      = e[5:0];
            sample_enable = (e >= en_from);
            rx_in         = (e + 2 == glitch) ? ~val : val;
        end
        check($sformatf("%s strobes", tag), strobes, exp_strobes);
        if (exp_strobes == 1) begin
            check($sformatf("%s pos", tag), pos, exp_pos);
            check($sformatf("%s bit", tag), got_bit, exp_bit);
            check($sformatf("%s noise", tag), got_noise, exp_noise);
        end
    endtask

    initial begin
        int strobes;
        rst           = 1'b0;
        rx_in         = 1'b1;
        sample_enable = 1'b0;
        prescale      = 6'd16;
        edge_cnt      = 6'd0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst bit", bus_a.sampled_bit, 1'b1);
        check("rst valid", bus_a.sampled_valid, 1'b0);
        check("rst noise", bus_a.noise_flag, 1'b0);
        check("rst cfg_err", bus_a.cfg_err, 1'b0);
        rst = 1'b0;

        run_bit("p16 zero", 1'b0, 16, 1'b0, -1, 0, 1, 10, 1'b0, 1'b0);
        run_bit("p8 glitch", 1'b0, 8, 1'b1, 4, 0, 1, 6, 1'b1, 1'b1);
        check("b cfg p8", bus_b.cfg_err, 1'b1);
        run_bit("p8 zero", 1'b0, 8, 1'b0, -1, 0, 1, 6, 1'b0, 1'b0);
        run_bit("late en", 1'b0, 16, 1'b0, -1, 8, 0, 0, 1'b0, 1'b0);
        run_bit("after late", 1'b0, 16, 1'b1, -1, 0, 1, 10, 1'b1, 1'b0);

        prescale = 6'd5;
        #1 check("cfg p5", bus_a.cfg_err, 1'b1);
        for (int i = 0; i < 3; i++) run_bit("p5 blocked", 1'b0, 5, 1'b0, -1, 0, 0, 0, 1'b0, 1'b0);
        prescale = 6'd4;
        #1 check("cfg p4", bus_a.cfg_err, 1'b1);
        for (int i = 0; i < 3; i++) run_bit("p4 blocked", 1'b0, 4, 1'b0, -1, 0, 0, 0, 1'b0, 1'b0);
        check("cfg hold bit", bus_a.sampled_bit, 1'b1);
        prescale = 6'd16;
        #1 check("cfg p16", bus_a.cfg_err, 1'b0);
        check("b cfg p16", bus_b.cfg_err, 1'b0);
        run_bit("resume", 1'b0, 16, 1'b0, -1, 0, 1, 10, 1'b0, 1'b0);
        run_bit("p16 noisy0", 1'b0, 16, 1'b0, 8, 0, 1, 10, 1'b0, 1'b1);

        strobes = 0;
        for (int e = 0; e < 16; e++) begin
            @(negedge clk);
            if (bus_a.sampled_valid) strobes++;
            edge_cnt      = e[5:0];
            sample_enable = 1'b1;
            rx_in         = 1'b0;
            if (e == 8) begin
                rst = 1'b1;
                #1;
                check("midrst bit", bus_a.sampled_bit, 1'b1);
                check("midrst noise", bus_a.noise_flag, 1'b0);
                check("midrst valid", bus_a.sampled_valid, 1'b0);
            end
        end
        check("midrst strobes", strobes, 0);
        rst = 1'b0;
        run_bit("post rst", 1'b0, 16, 1'b0, -1, 0, 1, 10, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_bit($sformatf("n5 bit%0d", i), 1'b1, 32, i[0], -1, 0, 1, 19, i[0], 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
